// File: rtl/sound_pkg.sv
// Shared constants for the sound-CPU command latch: IM0 vectors and vector bit positions.
package sound_pkg;

    localparam logic [7:0] VEC_NONE  = 8'hFF;
    localparam logic [7:0] VEC_YM    = 8'hEF;
    localparam logic [7:0] VEC_LATCH = 8'hDF;
    localparam logic [7:0] VEC_BOTH  = 8'hCF;

    localparam int YM_BIT_POS    = 4;
    localparam int LATCH_BIT_POS = 5;

    // RST-style vector: each pending source clears its own bit of FF.
    function automatic logic [7:0] irq_vec(
        input logic ym,
        input logic lp,
        input int   ybit,
        input int   lbit
    );
        logic [7:0] v;
        v = VEC_NONE;
        v[ybit[2:0]] = v[ybit[2:0]] & ~ym;
        v[lbit[2:0]] = v[lbit[2:0]] & ~lp;
        return v;
    endfunction

endpackage

// File: rtl/snd_latch_fifo.sv
// Byte FIFO behind the sound command latch (used only with SND_LATCH_FIFO_EN).
// Push when full is refused unless a pop happens in the same cycle.
module snd_latch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       empty_nxt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push) begin
            wr_d = wr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    assign empty_nxt_o = (cnt_d == '0);
    assign head_o      = empty_o ? 8'h00 : mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sound_latch_rx.sv
// Z80 end of the main->sound command latch with YM2151 IRQ merge and IM0 vector.
// Define SND_LATCH_FIFO_EN to replace the single register with a FIFO_DEPTH-byte FIFO.
module sound_latch_rx
    import sound_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int VEC_YM_BIT    = YM_BIT_POS,
    parameter int VEC_LATCH_BIT = LATCH_BIT_POS
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       latch_wr,
    input  logic [7:0] latch_din,
    output logic       latch_rdy,
    input  logic       z80_rd,
    input  logic       z80_ack,
    output logic [7:0] latch_dout,
    input  logic       ym_irq_n,
    output logic       z80_int_n,
    output logic [7:0] int_vector,
    output logic       overflow
);

    logic prev_q;
    logic ym_pend_q, ym_pend_d;
    logic int_n_q, int_n_d;
    logic ovf_q, ovf_d;
    logic wr_edge;
    logic latch_pend;
    logic latch_pend_d;
    logic drop;

    assign wr_edge   = latch_wr & ~prev_q;
    assign ym_pend_d = ~ym_irq_n;

`ifdef SND_LATCH_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_empty_nxt;
    logic [7:0] fifo_head;
    logic       unused_rd;

    snd_latch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .push_i     (wr_edge),
        .pop_i      (z80_ack),
        .din_i      (latch_din),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .empty_nxt_o(fifo_empty_nxt)
    );

    assign latch_pend   = ~fifo_empty;
    assign latch_pend_d = ~fifo_empty_nxt;
    assign drop         = wr_edge & fifo_full & ~z80_ack;
    assign latch_dout   = fifo_head;
    assign latch_rdy    = ~fifo_full;
    assign unused_rd    = z80_rd;
`else
    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;
    logic       unused_rd;

    // A write in the ack cycle replaces an already-released byte: no overflow.
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        drop   = 1'b0;
        if (wr_edge) begin
            data_d = latch_din;
            pend_d = 1'b1;
            drop   = pend_q & ~z80_ack;
        end else if (z80_ack) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 8'h00;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign latch_pend   = pend_q;
    assign latch_pend_d = pend_d;
    assign latch_dout   = data_q;
    assign latch_rdy    = ~pend_q;
    assign unused_rd    = ^{z80_rd, FIFO_DEPTH[0]};
`endif

    assign ovf_d   = ovf_q | drop;
    assign int_n_d = ~(ym_pend_d | latch_pend_d);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= 1'b1;
            ym_pend_q <= 1'b0;
            int_n_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= latch_wr;
            ym_pend_q <= ym_pend_d;
            int_n_q   <= int_n_d;
            ovf_q     <= ovf_d;
        end
    end

    assign z80_int_n  = int_n_q;
    assign overflow   = ovf_q;
    assign int_vector = irq_vec(ym_pend_q, latch_pend,
                                VEC_YM_BIT, VEC_LATCH_BIT);

endmodule
